clmul_unit: RTL
===============

CLMUL_UNIT -- requirements
Module: clmul_unit

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 4: operand-2 bits processed per compute cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have port s_clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port s_resetn_i  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port s_start_i  input  1  request from the execute stage to begin a carry-less multiply.
REQ-005 SHALL have port s_mode_i  input  2  operation select, clmul_mode_t: CLMUL=0, CLMULH=1, CLMULR=2, 3 reserved.
REQ-006 SHALL have port s_op1_i  input  32  multiplicand (rs1).
REQ-007 SHALL have port s_op2_i  input  32  multiplier (rs2).
REQ-008 SHALL have port s_flush_i  input  1  pipeline kill; aborts any operation in flight.
REQ-009 SHALL have port s_busy_o  output  1  unit occupied; execute stage stalls while high.
REQ-010 SHALL have port s_valid_o  output  1  one-cycle pulse, s_result_o is the new result.
REQ-011 SHALL have port s_result_o  output  32  registered result, fed to the execute-stage result mux.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL accept a request only in IDLE with s_start_i=1 and s_flush_i=0; at that edge it captures s_op1_i, s_op2_i and s_mode_i, clears the 64-bit accumulator and the step counter, and enters CALC.
REQ-014 SHALL ignore s_start_i in CALC and DONE; operand inputs are don't-care after capture.
REQ-015 SHALL, on each CALC cycle, process the next BITS_PER_CYCLE bits of captured op2, LSB first: for each set bit at position k, acc ^= zero-extended op1 << k.
REQ-016 SHALL remain in CALC for exactly N=32/BITS_PER_CYCLE cycles, then enter DONE, with a step counter of ceil(log2(N)) bits and no wrap beyond N-1.
REQ-017 SHALL load s_result_o on the CALC-to-DONE edge: CLMUL acc[31:0], CLMULH acc[63:32], CLMULR acc[62:31], reserved mode 32'd0.
REQ-018 SHALL assert s_valid_o only in DONE, for one cycle, with DONE always returning to IDLE on the next edge; total latency is N+1 cycles from the accept edge to the valid cycle (9 for default).
REQ-019 SHALL drive s_busy_o=1 in CALC and DONE and 0 in IDLE, so a new request is accepted at the earliest on the edge ending DONE+1.
REQ-020 SHALL hold s_result_o between valid pulses, changing only per REQ-017 or reset.
REQ-021 SHALL, when s_flush_i=1 in any state, go to IDLE on the next edge without loading s_result_o. In DONE, s_valid_o is suppressed that cycle. Flush wins over a simultaneous start.
REQ-022 SHALL produce N-independent results: every legal BITS_PER_CYCLE gives identical s_result_o for identical operands.

Reset
REQ-023 SHALL, when s_resetn_i=0 at a rising edge, go to IDLE and clear the accumulator, the counter, the captured operands and s_result_o to 0, regardless of the current state, including mid-CALC.
REQ-024 SHALL drive s_busy_o=0 and s_valid_o=0 in the cycle after the reset edge.

Structure
REQ-025 SHALL take clmul_mode_t and its encodings from the shared package p_hardisc, alongside the existing bit-manipulation function codes.
REQ-026 SHALL use one combinational sub-module, clmul_step: inputs acc[63:0], op1[31:0], a BITS_PER_CYCLE op2 slice and a base bit position; output the next acc.
REQ-027 SHALL flag an illegal BITS_PER_CYCLE with an elaboration-time assertion.

Verification
REQ-028 SHALL test basic CLMUL: CLMUL 0x00000003 x 0x00000003, default parameter -> s_valid_o 9 cycles after accept, s_result_o=0x00000005, s_busy_o high 9 cycles.
REQ-029 SHALL test the high and reversed forms: CLMULH 0x80000000 x 0x80000000 -> 0x40000000; CLMULR same operands -> 0x80000000.
REQ-030 SHALL test all-ones operands: 0xFFFFFFFF x 0xFFFFFFFF -> CLMUL 0x55555555, CLMULH 0x55555555, repeated at BITS_PER_CYCLE 1, 2, 8 with equal results and latencies 33/17/5.
REQ-031 SHALL test flush: s_flush_i during 3rd CALC cycle -> no s_valid_o, s_busy_o low next cycle, s_result_o unchanged; a following start then completes normally.
REQ-032 SHALL test start while busy: second s_start_i pulsed during CALC and DONE -> ignored, exactly one valid pulse, first operands' result.
REQ-033 SHALL test reset mid-CALC: s_resetn_i low one cycle -> IDLE, s_busy_o=0, s_result_o=0, no valid pulse.

Source files
------------

// File: rtl/p_hardisc.sv
// p_hardisc: shared core definitions, bit-manipulation function codes and clmul mode encodings
package p_hardisc;
  localparam logic [6:0] FUNCT7_CLMUL  = 7'b0000101;
  localparam logic [2:0] FUNCT3_CLMUL  = 3'b001;
  localparam logic [2:0] FUNCT3_CLMULR = 3'b010;
  localparam logic [2:0] FUNCT3_CLMULH = 3'b011;
  typedef enum logic [1:0] {
    CLMUL      = 2'd0,
    CLMULH     = 2'd1,
    CLMULR     = 2'd2,
    CLMUL_RSVD = 2'd3
  } clmul_mode_t;
  function automatic logic [31:0] clmul_select(input clmul_mode_t m, input logic [63:0] acc);
    return m == CLMUL ? acc[31:0] : m == CLMULH ? acc[63:32] : m == CLMULR ? acc[62:31] : 32'd0;
  endfunction
endpackage

// File: rtl/clmul_unit_step.sv
// clmul_step: folds one op2 slice into the 64-bit carry-less accumulator
module clmul_step
  import p_hardisc::*;
#(
  parameter int BITS = 4
) (
  input  logic [63:0]     acc,
  input  logic [31:0]     op1,
  input  logic [BITS-1:0] slice,
  input  logic [4:0]      base,
  output logic [63:0]     acc_next
);
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < BITS; k++)
      if (slice[k]) acc_next = acc_next ^ ({32'd0, op1} << (32'(base) + k));
  end
endmodule

// File: rtl/clmul_unit.sv
// clmul_unit: iterative carry-less multiply (CLMUL/CLMULH/CLMULR), BITS_PER_CYCLE op2 bits per step
module clmul_unit
  import p_hardisc::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_start_i,
  input  logic [1:0]  s_mode_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  input  logic        s_flush_i,
  output logic        s_busy_o,
  output logic        s_valid_o,
  output logic [31:0] s_result_o
);
  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8))
      begin : g_bad_bpc
        $error("clmul_unit: BITS_PER_CYCLE must be 1, 2, 4 or 8");
      end
  endgenerate

  logic [1:0]  state;
  logic [CW-1:0] cnt;
  logic [63:0] acc, acc_next;
  logic [31:0] op1_q, op2_q;
  clmul_mode_t mode_q;
  logic [4:0]  base;

  assign base = 5'(32'(cnt) * BITS_PER_CYCLE);

  clmul_step #(.BITS(BITS_PER_CYCLE)) u_step (
    .acc      (acc),
    .op1      (op1_q),
    .slice    (op2_q[base +: BITS_PER_CYCLE]),
    .base     (base),
    .acc_next (acc_next)
  );

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      mode_q     <= CLMUL;
      s_result_o <= '0;
    end else if (s_flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (s_start_i) begin
          state  <= CALC;
          cnt    <= '0;
          acc    <= '0;
          op1_q  <= s_op1_i;
          op2_q  <= s_op2_i;
          mode_q <= clmul_mode_t'(s_mode_i);
        end
        CALC: begin
          acc <= acc_next;
          // the last step's accumulator is only available as acc_next, so select from it
          if (cnt == CW'(N - 1)) begin
            state      <= DONE;
            s_result_o <= clmul_select(mode_q, acc_next);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_busy_o  = state != IDLE;
  assign s_valid_o = state == DONE && !s_flush_i;
endmodule
